// File: rtl/mmu_addresses_pkg.sv
// CPU memory-map addresses shared by blocks attached to the MMU.
package mmu_addresses_pkg;

    localparam logic [15:0] DMA_OAM_addr = 16'hFF46;
    localparam logic [15:0] OAM_start    = 16'hFE00;

endpackage

// File: rtl/ppu_types_pkg.sv
// PPU-side shared types and constants, including the OAM DMA engine state.
package ppu_types_pkg;

    localparam int unsigned OAM_DMA_LEN = 160;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } oam_dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to FF46 copies 160 bytes from {src_hi,00} into OAM at FE00.
// Optional macro OAM_DMA_SRC_REMAP_EN folds echo-RAM sources (E0..FF) down by 0x20.
module oam_dma
    import mmu_addresses_pkg::*;
    import ppu_types_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BYTE = 4,
    parameter int unsigned START_DELAY     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reg_write_en,
    input  logic        reg_read_en,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic [15:0] dma_addr,
    output logic        dma_read_en,
    input  logic [7:0]  dma_rdata,
    output logic        dma_write_en,
    output logic [7:0]  dma_wdata,
    output logic        busy
);

    localparam int unsigned SLOT_W  = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam int unsigned DELAY_W = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(CYCLES_PER_BYTE - 1);
    localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'(START_DELAY - 1);
    localparam logic [7:0]         LAST_BYTE  = 8'(OAM_DMA_LEN - 1);

    oam_dma_state_t     state, state_next;
    logic [DELAY_W-1:0] delay_cnt, delay_next;
    logic [SLOT_W-1:0]  slot_cnt, slot_next;
    logic [7:0]         byte_idx, idx_next;
    logic [7:0]         src_hi, src_next;
    logic [7:0]         data_q, data_next;
    logic [7:0]         src_eff;
    logic               trigger;

    logic [15:0] addr_next;
    logic [7:0]  wdata_next;
    logic        read_next;
    logic        write_next;
    logic        busy_next;

    assign trigger = reg_write_en && (reg_addr == DMA_OAM_addr);

    // Register reads are combinational and allowed at any time, including mid-transfer.
    assign reg_rdata = (reg_read_en && (reg_addr == DMA_OAM_addr)) ? src_hi : 8'hFF;

`ifdef OAM_DMA_SRC_REMAP_EN
    assign src_eff = (src_next >= 8'hE0) ? (src_next - 8'h20) : src_next;
`else
    assign src_eff = src_next;
`endif

    // Next-state: a trigger always wins, restarting from byte 0 even mid-slot.
    always_comb begin
        state_next = state;
        delay_next = delay_cnt;
        slot_next  = slot_cnt;
        idx_next   = byte_idx;
        src_next   = src_hi;
        data_next  = data_q;
        if (trigger) begin
            state_next = START;
            delay_next = '0;
            slot_next  = '0;
            idx_next   = '0;
            src_next   = reg_wdata;
        end else begin
            unique case (state)
                IDLE: state_next = IDLE;
                START: begin
                    if (delay_cnt == DELAY_LAST) begin
                        state_next = XFER;
                        slot_next  = '0;
                    end else begin
                        delay_next = delay_cnt + DELAY_W'(1);
                    end
                end
                XFER: begin
                    if (slot_cnt == '0) begin
                        data_next = dma_rdata;
                    end
                    if (slot_cnt == SLOT_LAST) begin
                        slot_next = '0;
                        if (byte_idx == LAST_BYTE) begin
                            state_next = IDLE;
                        end else begin
                            idx_next = byte_idx + 8'd1;
                        end
                    end else begin
                        slot_next = slot_cnt + SLOT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output next-values derived from where the engine will be next cycle.
    always_comb begin
        read_next  = 1'b0;
        write_next = 1'b0;
        addr_next  = dma_addr;
        wdata_next = dma_wdata;
        busy_next  = (state_next != IDLE);
        if (state_next == XFER) begin
            if (slot_next == '0) begin
                read_next = 1'b1;
                addr_next = {src_eff, idx_next};
            end else if (slot_next == SLOT_W'(1)) begin
                write_next = 1'b1;
                addr_next  = OAM_start + 16'(idx_next);
                wdata_next = data_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            delay_cnt    <= '0;
            slot_cnt     <= '0;
            byte_idx     <= '0;
            src_hi       <= 8'hFF;
            data_q       <= '0;
            dma_addr     <= '0;
            dma_wdata    <= '0;
            dma_read_en  <= 1'b0;
            dma_write_en <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            delay_cnt    <= delay_next;
            slot_cnt     <= slot_next;
            byte_idx     <= idx_next;
            src_hi       <= src_next;
            data_q       <= data_next;
            dma_addr     <= addr_next;
            dma_wdata    <= wdata_next;
            dma_read_en  <= read_next;
            dma_write_en <= write_next;
            busy         <= busy_next;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed and randomized bench for oam_dma against a cycle-indexed transfer model.
module tb_oam_dma;

    localparam int CPB         = 4;
    localparam int SD          = 4;
    localparam int LEN         = 160;
    localparam int BUSY_CYCLES = SD + LEN * CPB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reg_write_en;
    logic        reg_read_en;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic [15:0] dma_addr;
    logic        dma_read_en;
    logic [7:0]  dma_rdata;
    logic        dma_write_en;
    logic [7:0]  dma_wdata;
    logic        busy;

    logic [7:0] mem [0:65535];
    logic [7:0] d;
    logic [7:0] s1;
    logic [7:0] s2;
    int         kb;
    int         errors = 0;
    int         checks = 0;

    oam_dma #(.CYCLES_PER_BYTE(CPB), .START_DELAY(SD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .reg_write_en (reg_write_en),
        .reg_read_en  (reg_read_en),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .dma_addr     (dma_addr),
        .dma_read_en  (dma_read_en),
        .dma_rdata    (dma_rdata),
        .dma_write_en (dma_write_en),
        .dma_wdata    (dma_wdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Source memory answers in the same cycle as the read strobe.
    assign dma_rdata = dma_read_en ? mem[dma_addr] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] eff_src(input logic [7:0] s);
`ifdef OAM_DMA_SRC_REMAP_EN
        return (s >= 8'hE0) ? (s - 8'h20) : s;
`else
        return s;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [7:0] v);
        reg_write_en = 1'b1;
        reg_addr     = a;
        reg_wdata    = v;
        step();
        reg_write_en = 1'b0;
        reg_addr     = 16'h0000;
        reg_wdata    = 8'h00;
    endtask

    task automatic reg_read(input logic [15:0] a, input logic rd, output logic [7:0] v);
        reg_read_en = rd;
        reg_addr    = a;
        #1;
        v           = reg_rdata;
        reg_read_en = 1'b0;
        reg_addr    = 16'h0000;
    endtask

    // Cycle n counts from the first cycle after the trigger edge.
    task automatic observe(input logic [7:0] src, input int cycles, input string tag);
        logic [7:0] eff;
        int         writes;
        int         b;
        int         ph;
        bit         in_x;
        bit         exp_rd;
        bit         exp_wr;
        eff    = eff_src(src);
        writes = 0;
        for (int n = 0; n < cycles; n++) begin
            in_x   = (n >= SD) && (n < BUSY_CYCLES);
            b      = in_x ? (n - SD) / CPB : 0;
            ph     = in_x ? (n - SD) % CPB : 0;
            exp_rd = in_x && (ph == 0);
            exp_wr = in_x && (ph == 1);
            chk($sformatf("%s busy n=%0d", tag, n), 32'(busy), 32'(n < BUSY_CYCLES));
            chk($sformatf("%s read_en n=%0d", tag, n), 32'(dma_read_en), 32'(exp_rd));
            chk($sformatf("%s write_en n=%0d", tag, n), 32'(dma_write_en), 32'(exp_wr));
            if (exp_rd) begin
                chk($sformatf("%s rd_addr n=%0d", tag, n), 32'(dma_addr), 32'({eff, 8'(b)}));
            end
            if (exp_wr) begin
                chk($sformatf("%s wr_addr n=%0d", tag, n), 32'(dma_addr), 32'(16'hFE00 + 16'(b)));
                chk($sformatf("%s wdata n=%0d", tag, n), 32'(dma_wdata), 32'(mem[{eff, 8'(b)}]));
            end
            if (dma_write_en) writes++;
            step();
        end
        if (cycles >= BUSY_CYCLES) begin
            chk({tag, " write_count"}, 32'(writes), 32'(LEN));
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        reg_write_en = 1'b0;
        reg_read_en  = 1'b0;
        reg_addr     = 16'h0000;
        reg_wdata    = 8'h00;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < LEN; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;

        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'(0));
        chk("rst read_en", 32'(dma_read_en), 32'(0));
        chk("rst write_en", 32'(dma_write_en), 32'(0));
        chk("rst addr", 32'(dma_addr), 32'(0));
        chk("rst wdata", 32'(dma_wdata), 32'(0));
        reg_read(16'hFF46, 1'b1, d);
        chk("rst src_hi", 32'(d), 32'(8'hFF));
        reset_n = 1'b1;
        step();

        // Writes elsewhere are ignored.
        reg_write(16'hFF47, 8'h12);
        repeat (6) begin
            chk("ff47 busy", 32'(busy), 32'(0));
            chk("ff47 strobes", 32'(dma_read_en | dma_write_en), 32'(0));
            step();
        end
        reg_read(16'hFF46, 1'b1, d);
        chk("ff47 src_hi kept", 32'(d), 32'(8'hFF));

        reg_write(16'hFF46, 8'hC1);
        observe(8'hC1, 700, "c1");

        // Register reads while busy.
        reg_write(16'hFF46, 8'h80);
        reg_read(16'hFF46, 1'b1, d);
        chk("read ff46", 32'(d), 32'(8'h80));
        reg_read(16'hFF46, 1'b0, d);
        chk("read no strobe", 32'(d), 32'(8'hFF));
        reg_read(16'hFF47, 1'b1, d);
        chk("read ff47", 32'(d), 32'(8'hFF));
        observe(8'h80, 700, "s80");

        // Directed retrigger at byte 50.
        reg_write(16'hFF46, 8'hC1);
        observe(8'hC1, SD + 50 * CPB, "rt1");
        chk("rt1 byte50 read", 32'(dma_read_en), 32'(1));
        reg_write(16'hFF46, 8'hC2);
        observe(8'hC2, 700, "rt2");

        // Randomized retrigger point and sources.
        for (int r = 0; r < 3; r++) begin
            s1 = 8'($urandom);
            s2 = 8'($urandom);
            kb = int'($urandom_range(0, LEN - 1));
            reg_write(16'hFF46, s1);
            observe(s1, SD + kb * CPB + int'($urandom_range(0, CPB - 1)), "rnd1");
            reg_write(16'hFF46, s2);
            observe(s2, 700, "rnd2");
        end

        // Trigger coinciding with the final write.
        reg_write(16'hFF46, 8'hC1);
        observe(8'hC1, BUSY_CYCLES - CPB + 1, "fin1");
        chk("fin1 last write", 32'(dma_write_en), 32'(1));
        chk("fin1 last addr", 32'(dma_addr), 32'(16'hFE9F));
        reg_write(16'hFF46, 8'hD0);
        observe(8'hD0, 700, "fin2");

        // Echo-range sources.
        reg_write(16'hFF46, 8'hFE);
        observe(8'hFE, 700, "srcFE");
        reg_write(16'hFF46, 8'hE0);
        observe(8'hE0, 700, "srcE0");

        // Asynchronous reset during byte 80.
        reg_write(16'hFF46, 8'hC1);
        observe(8'hC1, SD + 80 * CPB + 1, "rst80");
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst busy", 32'(busy), 32'(0));
        chk("arst read_en", 32'(dma_read_en), 32'(0));
        chk("arst write_en", 32'(dma_write_en), 32'(0));
        chk("arst addr", 32'(dma_addr), 32'(0));
        chk("arst wdata", 32'(dma_wdata), 32'(0));
        step();
        step();
        reset_n = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            chk($sformatf("post-rst idle n=%0d", n), 32'({busy, dma_read_en, dma_write_en}), 32'(0));
            step();
        end
        reg_read(16'hFF46, 1'b1, d);
        chk("post-rst src_hi", 32'(d), 32'(8'hFF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
